// File: rtl/div_seq_4bit.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_4bit
// Description : Sequential restoring unsigned divider, 2*SIZE / SIZE bits,
//               one quotient bit per clock, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_4bit #(
    parameter int SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*SIZE-1:0]     dividend,
    input  logic [SIZE-1:0]       divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*SIZE-1:0]     quotient,
    output logic [SIZE-1:0]       remainder,
    output logic                  div_by_zero
);

    localparam int N  = 2 * SIZE;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [SIZE-1:0]   div_reg;
    // Restoring keeps the partial remainder below the divisor, so SIZE bits
    // hold it; only the trial value needs the extra bit.
    logic [SIZE-1:0]   work_rem;
    logic [N-1:0]      work_q;
    logic [CW-1:0]     step_cnt;

    logic              accept;
    logic              last_step;
    logic [SIZE:0]     trial;
    logic              fits;
    logic [SIZE-1:0]   diff;
    logic [SIZE-1:0]   rem_next;
    logic [N-1:0]      q_next;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (step_cnt == LAST_STEP) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits.
    always_comb begin
        trial    = {work_rem, work_q[N-1]};
        fits     = (trial >= {1'b0, div_reg});
        diff     = trial[SIZE-1:0] - div_reg;
        rem_next = fits ? diff : trial[SIZE-1:0];
        q_next   = {work_q[N-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= '0;
            work_rem    <= '0;
            work_q      <= '0;
            step_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_reg  <= divisor;
                        work_rem <= '0;
                        work_q   <= dividend;
                        step_cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[SIZE-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    work_rem <= rem_next;
                    work_q   <= q_next;
                    step_cnt <= step_cnt + CW'(1);
                    if (last_step) begin
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_4bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_4bit
// Description : Self-checking bench for div_seq_4bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int errors;

    div_seq_4bit #(.SIZE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request with out_ready high and check result and latency.
    // Latency counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = v.dvd;
        divisor   = v.dvs;
        out_ready = 1'b1;
        chk({name, " in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'hxx;
        divisor  = 4'hx;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, v.lat);
        chk({name, " quotient"}, int'(quotient), int'(v.q));
        chk({name, " remainder"}, int'(remainder), int'(v.r));
        chk({name, " div_by_zero"}, int'(div_by_zero), int'(v.dz));
        @(negedge clk);
        chk({name, " out_valid cleared"}, int'(out_valid), 0);
        chk({name, " in_ready back"}, int'(in_ready), 1);
    endtask

    vec_t vecs[11];

    logic [7:0] exp_dvd_q[$];
    logic [3:0] exp_dvs_q[$];

    initial begin
        int accepted;
        int results;
        int guard;
        logic [7:0] ed;
        logic [3:0] es;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9};
        vecs[1]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9};
        vecs[2]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 9};
        vecs[3]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9};
        vecs[4]  = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 9};
        vecs[5]  = '{8'h0D,  4'd0,  8'hFF,  4'hD,  1'b1, 1};
        vecs[6]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9};
        vecs[7]  = '{8'd255, 4'd0,  8'hFF,  4'hF,  1'b1, 1};
        vecs[8]  = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 9};
        vecs[9]  = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0, 9};
        vecs[10] = '{8'd90,  4'd6,  8'd15,  4'd0,  1'b0, 9};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst quotient", int'(quotient), 0);
        chk("rst remainder", int'(remainder), 0);
        chk("rst div_by_zero", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready", int'(in_ready), 1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: stalled result must hold, in_valid ignored.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd100;
        divisor   = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp calc in_ready", int'(in_ready), 0);
        guard = 0;
        while (!out_valid && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid held", int'(out_valid), 1);
            chk("bp quotient held", int'(quotient), 11);
            chk("bp remainder held", int'(remainder), 1);
            chk("bp in_ready low", int'(in_ready), 0);
            in_valid = k[0];
            dividend = 8'd50;
            divisor  = 4'd3;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp transfer out_valid", int'(out_valid), 0);
        chk("bp transfer in_ready", int'(in_ready), 1);
        chk("bp quotient kept", int'(quotient), 11);
        repeat (12) begin
            @(negedge clk);
            chk("bp no extra result", int'(out_valid), 0);
        end

        // Reset in the middle of CALC
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst quotient", int'(quotient), 0);
        chk("midrst remainder", int'(remainder), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("midrst no spurious", int'(out_valid), 0);
        end
        run_vec(vecs[10], "post_rst 90/6");

        // Random back-to-back with random backpressure
        accepted = 0;
        results  = 0;
        guard    = 0;
        @(negedge clk);
        while ((accepted < 1000 || exp_dvd_q.size() != 0) && guard < 60000) begin
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (accepted < 1000) begin
                in_valid = 1'b1;
                dividend = 8'($urandom);
                divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_dvd_q.size() == 0) begin
                    chk("rnd unexpected result", 1, 0);
                end else begin
                    ed = exp_dvd_q.pop_front();
                    es = exp_dvs_q.pop_front();
                    results++;
                    if (es == 4'd0) begin
                        chk("rnd dz quotient", int'(quotient), 255);
                        chk("rnd dz remainder", int'(remainder), int'(ed[3:0]));
                        chk("rnd dz flag", int'(div_by_zero), 1);
                    end else begin
                        chk("rnd quotient", int'(quotient), int'(ed) / int'(es));
                        chk("rnd remainder", int'(remainder), int'(ed) % int'(es));
                        chk("rnd flag", int'(div_by_zero), 0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_dvd_q.push_back(dividend);
                exp_dvs_q.push_back(divisor);
                accepted++;
            end
            @(negedge clk);
        end
        chk("rnd results count", results, 1000);
        chk("rnd queue drained", exp_dvd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
